// File: rtl/alu_seq.sv
// Registered EXE-stage ALU with an NZCV status register and a valid/ready handshake.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for command 1010.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_command,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    input  logic             s_update,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       status_register,
    output logic             busy
);
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] CMD_MUL = 4'b1010;
`endif
    localparam int MSB = WIDTH - 1;

    // Handshake: an operation transfers on a rising edge where in_valid && in_ready;
    // out_valid is a one-cycle pulse and alu_out holds until the next pulse.

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_cin;
    logic             sub_cin;
    logic [WIDTH-1:0] op_res;
    logic             op_arith;
    logic             op_c;
    logic             op_v;

    // Subtract is A + ~B + cin, so the carry out is the ARM-style NOT borrow.
    always_comb begin
        add_cin  = (alu_command == CMD_ADC) ? status_register[2] : 1'b0;
        sub_cin  = (alu_command == CMD_SBC) ? status_register[2] : 1'b1;
        add_sum  = {1'b0, alu_in1} + {1'b0, alu_in2} + {{WIDTH{1'b0}}, add_cin};
        sub_sum  = {1'b0, alu_in1} + {1'b0, ~alu_in2} + {{WIDTH{1'b0}}, sub_cin};
        op_res   = '0;
        op_arith = 1'b0;
        op_c     = 1'b0;
        op_v     = 1'b0;
        case (alu_command)
            CMD_MOV: op_res = alu_in2;
            CMD_MVN: op_res = ~alu_in2;
            CMD_AND: op_res = alu_in1 & alu_in2;
            CMD_ORR: op_res = alu_in1 | alu_in2;
            CMD_EOR: op_res = alu_in1 ^ alu_in2;
            CMD_ADD, CMD_ADC: begin
                op_res   = add_sum[WIDTH-1:0];
                op_arith = 1'b1;
                op_c     = add_sum[WIDTH];
                op_v     = (alu_in1[MSB] == alu_in2[MSB]) && (add_sum[MSB] != alu_in1[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                op_res   = sub_sum[WIDTH-1:0];
                op_arith = 1'b1;
                op_c     = sub_sum[WIDTH];
                op_v     = (alu_in1[MSB] != alu_in2[MSB]) && (sub_sum[MSB] != alu_in1[MSB]);
            end
            default: op_res = '0;
        endcase
    end

    function automatic logic [3:0] flags_next(input logic [3:0]       cur,
                                              input logic [WIDTH-1:0] res,
                                              input logic             arith,
                                              input logic             c,
                                              input logic             v);
        logic [3:0] f;
        f    = cur;
        f[3] = (res == '0);
        f[1] = res[MSB];
        if (arith) begin
            f[2] = c;
            f[0] = v;
        end
        return f;
    endfunction

`ifdef ALU_SEQ_MUL_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             mul_s;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_MUL);
    assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            alu_out         <= '0;
            status_register <= '0;
`ifdef ALU_SEQ_MUL_EN
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            mul_s  <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            if (in_valid && in_ready && (alu_command == CMD_MUL)) begin
                mcand  <= alu_in1;
                mplier <= alu_in2;
                acc    <= '0;
                cnt    <= CNT_W'(WIDTH);
                mul_s  <= s_update;
                state  <= ST_MUL;
            end else
`endif
            if (in_valid && in_ready) begin
                alu_out   <= op_res;
                out_valid <= 1'b1;
                if (s_update) begin
                    status_register <= flags_next(status_register, op_res, op_arith, op_c, op_v);
                end
            end
`ifdef ALU_SEQ_MUL_EN
            // One multiplier bit per cycle; the last add lands directly in alu_out.
            if (state == ST_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    alu_out   <= acc_next;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                    if (mul_s) begin
                        status_register <= flags_next(status_register, acc_next, 1'b0, 1'b0, 1'b0);
                    end
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized operations
// checked against an arithmetic reference model; MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
    localparam int WIDTH = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_command;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic             s_update;
    logic             out_valid;
    logic [WIDTH-1:0] alu_out;
    logic [3:0]       status_register;
    logic             busy;

    logic [WIDTH+3:0] exp_q[$];
    logic [3:0]       m_flags = 4'b0;
    int               n_checks = 0;
    int               n_fail = 0;
    int               ready_drops = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_command(alu_command), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .s_update(s_update), .out_valid(out_valid), .alu_out(alu_out),
        .status_register(status_register), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the ARM flag definitions.
    function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic [3:0] f_in,
                                  output logic [31:0] r, output logic [3:0] f_out);
        longint unsigned ua, ub, cu, full;
        longint sa, sb, cs, sr;
        bit arith, c_new, v_new;
        ua = a; ub = b;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        arith = 0; c_new = 0; v_new = 0; r = '0; full = 0; cu = 0; cs = 0; sr = 0;
        case (cmd)
            4'h1: r = b;
            4'h9: r = ~b;
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = a ^ b;
            4'h2, 4'h3: begin
                cu    = (cmd == 4'h3) ? longint'(f_in[2]) : 0;
                cs    = longint'(cu);
                full  = ua + ub + cu;
                r     = full[31:0];
                c_new = full[32];
                sr    = sa + sb + cs;
                v_new = (sr > SMAX) || (sr < SMIN);
                arith = 1;
            end
            4'h4, 4'h5: begin
                cu    = (cmd == 4'h5) ? longint'(1 - int'(f_in[2])) : 0;
                cs    = longint'(cu);
                c_new = (ua >= ub + cu);
                full  = ua - ub - cu;
                r     = full[31:0];
                sr    = sa - sb - cs;
                v_new = (sr > SMAX) || (sr < SMIN);
                arith = 1;
            end
`ifdef ALU_SEQ_MUL_EN
            4'hA: begin
                full = ua * ub;
                r    = full[31:0];
            end
`endif
            default: r = '0;
        endcase
        f_out = f_in;
        if (s) begin
            f_out[3] = (r == 0);
            f_out[1] = r[31];
            if (arith) begin
                f_out[2] = c_new;
                f_out[0] = v_new;
            end
        end
    endfunction

    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit use_exp = 0,
                         input logic [31:0] x_out = '0, input logic [3:0] x_st = '0);
        int guard;
        logic [31:0] r;
        logic [3:0] st;
        guard = 0;
        @(negedge clk);
        alu_command = cmd; alu_in1 = a; alu_in2 = b; s_update = s; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", guard);
        end else begin
            model(cmd, a, b, s, m_flags, r, st);
            if (use_exp) begin
                r  = x_out;
                st = x_st;
            end
            m_flags = st;
            exp_q.push_back({r, st});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every out_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [WIDTH+3:0] e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got alu_out %h, required no pulse", alu_out);
            end else begin
                e = exp_q.pop_front();
                check("alu_out", alu_out, e[WIDTH+3:4]);
                check("status", {28'b0, status_register}, {28'b0, e[3:0]});
            end
        end
    end

`ifndef ALU_SEQ_MUL_EN
    always @(negedge clk) begin
        if (!rst && (!in_ready || busy)) ready_drops++;
    end
`endif

    initial begin
        logic [31:0] a, b;
        logic [3:0] c;
        logic s;
        int lat, low, pulses, g;

        rst = 1'b1; in_valid = 1'b1; alu_command = 4'b0010;
        alu_in1 = 32'd1; alu_in2 = 32'd1; s_update = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_alu_out", alu_out, 0);
        check("reset_status", status_register, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0; in_valid = 1'b0;

        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1, 1, 32'h8000_0000, 4'b0011);
        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 32'h0000_0000, 4'b1100);
        issue(4'b0011, 32'h0000_0001, 32'h0000_0001, 1, 1, 32'h0000_0003, 4'b0000);
        issue(4'b0100, 32'd5, 32'd5, 1, 1, 32'h0000_0000, 4'b1100);
        issue(4'b0100, 32'd3, 32'd5, 0, 1, 32'hFFFF_FFFE, 4'b1100);

`ifdef ALU_SEQ_MUL_EN
        issue(4'b1010, 32'd7, 32'd6, 1, 1, 32'd42, 4'b0100);
        lat = 0; low = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) check("busy_in_mul", busy, 1);
            if (n == 5) begin
                alu_command = 4'b0010; alu_in1 = 32'd1; alu_in2 = 32'd1;
                s_update = 1'b1; in_valid = 1'b1;
            end
            if (n == 8) in_valid = 1'b0;
            if (!in_ready) low++;
            if (out_valid) lat = n;
        end
        check("mul_latency", lat, 33);
        check("mul_ready_low", low, 32);

        issue(4'b1010, $urandom, $urandom, 1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_flags = 4'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_alu_out", alu_out, 0);
        check("abort_status", status_register, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort_no_out_valid", pulses, 0);
`else
        issue(4'b0010, 32'd0, 32'd1, 1, 1, 32'd1, 4'b0000);
        issue(4'b1010, 32'd7, 32'd6, 1, 1, 32'd0, 4'b1000);
`endif

        for (int i = 0; i < 200; i++) begin
            c = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            issue(c, a, b, s);
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end

        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", exp_q.size(), 0);
`ifndef ALU_SEQ_MUL_EN
        check("ready_never_drops", ready_drops, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the lab's combinational ALU, for the EXE stage of the ARM-style pipeline.
- Keeps the same 4-bit command encoding and the same status bit order.
- Adds an internal status register (NZCV) with ARM S-bit gating, so ADC and SBC take carry from the stored C flag.
- Adds a valid/ready handshake and an iterative multi-cycle multiply.

Parameters:
- WIDTH, 32: data width of operands and result (>= 4).
- CNT_W, $clog2(WIDTH)+1: width of the multiply iteration counter; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and command presented this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- alu_command  in  4  operation select; encoding below.
- alu_in1  in  WIDTH  operand A (Rn).
- alu_in2  in  WIDTH  operand B (shifter operand).
- s_update  in  1  when 1, the operation writes the status register.
- out_valid  out  1  one-cycle pulse; alu_out is valid.
- alu_out  out  WIDTH  registered result; holds its value until the next out_valid.
- status_register  out  4  registered flags: [3]=Z, [2]=C, [1]=N, [0]=V.
- busy  out  1  a multiply is in progress.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears state and outputs:
  - state=IDLE, in_ready=1, out_valid=0, alu_out=0, status_register=0, busy=0, internal counter and accumulators = 0.
  - rst overrides in_valid in the same cycle.
- Transfer occurs when in_valid & in_ready. Operands, command and s_update are captured on that edge.
- Command encoding:
  - 0001 MOV: B.
  - 1001 MVN: ~B.
  - 0010 ADD: A+B.
  - 0011 ADC: A+B+C.
  - 0100 SUB: A-B.
  - 0101 SBC: A-B-(1-C).
  - 0110 AND, 0111 ORR, 1000 EOR.
  - 1010 MUL: low WIDTH bits of A*B.
  - Any other code: result 0, treated as a logical op.
- C used by ADC/SBC is the stored status_register[2] at the accept edge.
- Arithmetic is done at WIDTH+1 bits:
  - Add: C = bit WIDTH of the sum.
  - Subtract: C = NOT borrow (ARM convention), i.e. C=1 when A >= B + (1-Cin) unsigned.
- V, computed from the new result R:
  - add: (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - sub: (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
- Flags are always computed from the result being written, never from the previous alu_out.
- Flag write rules (only when the captured s_update=1; otherwise all four flags hold):
  - Arithmetic ops: all four flags written.
  - Logical ops, MOV/MVN, MUL, unknown codes: N and Z written; C and V hold.
- State machine:
  - IDLE: in_ready=1. Non-MUL op accepted → alu_out/flags registered on the accept edge, out_valid=1 next cycle, stay IDLE (back-to-back throughput 1/cycle). MUL accepted → load multiplicand/multiplier, acc=0, cnt=WIDTH, go to MUL.
  - MUL: in_ready=0, busy=1. Each cycle shift-add one multiplier bit and decrement cnt. When cnt reaches 1, the final add writes alu_out and flags; out_valid pulses in the first IDLE cycle.
  - Total MUL latency: WIDTH+1 cycles from accept edge to out_valid.
- in_valid while in_ready=0 is ignored; no queuing, and the upstream holds the operation.
- Multiply by 0 still takes the full WIDTH iterations (fixed latency).
- Reset mid-MUL aborts with no out_valid and clears flags.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL (1010) behaves as above.
- Undefined:
  - The MUL state and counter are not built; busy is tied to 0 and in_ready to 1.
  - 1010 is handled as an unknown code: single cycle, result 0, Z=1 and N=0 if s_update.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 0x00000001 with s_update=1 → out_valid 1 cycle later; alu_out=0x80000000, status=0b0011 (N=1, V=1, Z=0, C=0).
- ADD 0xFFFFFFFF + 0x1 (s=1), then next cycle ADC 0x1 + 0x1 (s=1) → results 0x0 with status 0b1100, then 0x3 with status 0b0000.
- SUB 5-5 (s=1) → 0x0, Z=1, C=1. Then SUB 3-5 (s=0) → alu_out=0xFFFFFFFE, status still 0b1100.
- MUL 7*6 (s=1, WIDTH=32):
  - in_ready low for 32 cycles, and an ADD offered meanwhile is ignored.
  - out_valid 33 cycles after accept with alu_out=42, Z=0, N=0, C/V unchanged.
- Assert rst on cycle 10 of a MUL → next cycle in_ready=1, busy=0, alu_out=0, status=0, and no out_valid pulse follows.
- Compile without ALU_SEQ_MUL_EN, issue 1010 with s=1 → one-cycle result 0, status=0b1000, and in_ready never drops.
